// File: rtl/system_top.sv
// UART command processor: 8E1 frames in on RX_IN drive a 16x8 register file and an ALU; replies go out on TX_OUT.
// Latency: RF write 1 cycle after the data byte; a reply starts within 3 cycles of the last command byte.
// Backpressure: none on RX. Bytes that arrive while a reply is being sent are dropped. ALU replies go out as two back-to-back frames.
// Ports: REF_CLK/RST (async, active-low), RX_IN/TX_OUT serial lines (idle high),
//        parity_error/framing_error describe the last received frame.
module system_top #(
  parameter int BUS_WIDTH    = 8,
  parameter int RF_ADDR      = 4,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic REF_CLK,
  input  logic RST,
  input  logic RX_IN,
  output logic TX_OUT,
  output logic parity_error,
  output logic framing_error
);
  localparam int W  = BUS_WIDTH;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(BUS_WIDTH);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
  rx_state_t rx_st, rx_nxt;
  logic rx_meta, rx_sync, rx_prev, start_edge, rx_half, rx_tick;
  logic [CW-1:0] rx_cnt;
  logic [BW-1:0] rx_bit;
  logic [W-1:0]  rx_dat;
  logic          rx_par, rx_vld, rx_err;

  assign start_edge = rx_prev & ~rx_sync;
  assign rx_half    = (rx_cnt == HALF_END);
  assign rx_tick    = (rx_cnt == BIT_END);

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  if (start_edge) rx_nxt = RX_START;
      // A start bit that is high again at mid-bit was a glitch.
      RX_START: if (rx_half) rx_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == BW'(W - 1)) rx_nxt = RX_PAR;
      RX_PAR:   if (rx_tick) rx_nxt = RX_STOP;
      RX_STOP:  if (rx_tick) rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1; rx_sync <= 1'b1; rx_prev <= 1'b1;
      rx_st <= RX_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_dat <= '0; rx_par <= 1'b0;
      rx_vld <= 1'b0; rx_err <= 1'b0; parity_error <= 1'b0; framing_error <= 1'b0;
    end else begin
      rx_meta <= RX_IN;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      rx_st   <= rx_nxt;
      rx_vld  <= 1'b0;
      rx_err  <= 1'b0;
      if (rx_st == RX_IDLE || rx_nxt != rx_st || rx_tick) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + CW'(1);
      if (rx_st == RX_IDLE && start_edge) begin
        rx_bit <= '0;
        parity_error  <= 1'b0;
        framing_error <= 1'b0;
      end
      if (rx_st == RX_DATA && rx_tick) begin
        rx_dat <= {rx_sync, rx_dat[W-1:1]};
        rx_bit <= rx_bit + BW'(1);
      end
      if (rx_st == RX_PAR && rx_tick) rx_par <= rx_sync;
      if (rx_st == RX_STOP && rx_tick) begin
        if (rx_sync && ((^rx_dat) == rx_par)) rx_vld <= 1'b1;
        else begin
          rx_err        <= 1'b1;
          parity_error  <= ((^rx_dat) != rx_par);
          framing_error <= ~rx_sync;
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  tx_state_t tx_st, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [W+2:0]  tx_shift;
  logic          tx_tick, tx_busy, tx_start;
  logic [W-1:0]  tx_dat;

  assign tx_tick = (tx_cnt == BIT_END);
  assign tx_busy = (tx_st == TX_SHIFT);

  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      TX_IDLE:  if (tx_start) tx_nxt = TX_SHIFT;
      TX_SHIFT: if (tx_tick && tx_bit == 4'(W + 2)) tx_nxt = TX_IDLE;
      default:  tx_nxt = TX_IDLE;
    endcase
  end

  // TX_OUT is registered so the line never glitches; the shift register is
  // refilled with ones so the stop bit and idle level come out naturally.
  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      tx_st <= TX_IDLE; tx_cnt <= '0; tx_bit <= '0; tx_shift <= '1; TX_OUT <= 1'b1;
    end else begin
      tx_st <= tx_nxt;
      if (tx_st == TX_IDLE) begin
        tx_cnt <= '0;
        tx_bit <= '0;
        if (tx_start) begin
          tx_shift <= {1'b1, ^tx_dat, tx_dat, 1'b0};
          TX_OUT   <= 1'b0;
        end
      end else if (tx_tick) begin
        tx_cnt   <= '0;
        tx_bit   <= tx_bit + 4'd1;
        tx_shift <= {1'b1, tx_shift[W+2:1]};
        TX_OUT   <= tx_shift[1];
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

  // ---------------- register file and ALU ----------------
  logic [W-1:0]       rf [2**RF_ADDR];
  logic               rf_we;
  logic [RF_ADDR-1:0] rf_wa, addr_q;
  logic [2*W-1:0]     alu_res, send_val, send_buf;
  logic [1:0]         send_cnt;
  logic               load_send, send_two;
  logic [W-1:0]       op_a, op_b;

  assign op_a = rf[0];
  assign op_b = rf[1];

  always_comb begin
    alu_res = '0;
    case (rx_dat[3:0])
      4'h0: alu_res = {{W{1'b0}}, op_a} + {{W{1'b0}}, op_b};
      4'h1: alu_res = {{W{1'b0}}, op_a} - {{W{1'b0}}, op_b};
      4'h2: alu_res = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
      4'h3: alu_res = (op_b == '0) ? '0 : {{W{1'b0}}, op_a / op_b};
      4'h4: alu_res = {{W{1'b0}}, op_a & op_b};
      4'h5: alu_res = {{W{1'b0}}, op_a | op_b};
      4'h6: alu_res = {{W{1'b0}}, ~(op_a & op_b)};
      4'h7: alu_res = {{W{1'b0}}, ~(op_a | op_b)};
      4'h8: alu_res = {{W{1'b0}}, op_a ^ op_b};
      4'h9: alu_res = {{W{1'b0}}, ~(op_a ^ op_b)};
      4'hA: alu_res = {{(2*W-1){1'b0}}, op_a == op_b};
      4'hB: alu_res = {{(2*W-1){1'b0}}, op_a > op_b};
      4'hC: alu_res = {{(2*W-1){1'b0}}, op_a < op_b};
      4'hD: alu_res = {{W{1'b0}}, op_a >> 1};
      4'hE: alu_res = {{(W-1){1'b0}}, op_a, 1'b0};
      default: alu_res = '0;
    endcase
  end

  // ---------------- command FSM ----------------
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FN, SEND} cmd_state_t;
  cmd_state_t st, st_nxt;

  always_comb begin
    st_nxt    = st;
    rf_we     = 1'b0;
    rf_wa     = addr_q;
    load_send = 1'b0;
    send_val  = alu_res;
    send_two  = 1'b0;
    tx_start  = 1'b0;
    tx_dat    = send_buf[W-1:0];
    case (st)
      IDLE: if (rx_vld) begin
        case (rx_dat)
          8'hAA:   st_nxt = WR_ADDR;
          8'hBB:   st_nxt = RD_ADDR;
          8'hCC:   st_nxt = OPA;
          8'hDD:   st_nxt = ALU_FN;
          default: st_nxt = IDLE;
        endcase
      end
      WR_ADDR: if (rx_vld) st_nxt = WR_DATA;
      WR_DATA: if (rx_vld) begin rf_we = 1'b1; st_nxt = IDLE; end
      RD_ADDR: if (rx_vld) begin
        load_send = 1'b1;
        send_val  = {{W{1'b0}}, rf[rx_dat[RF_ADDR-1:0]]};
        st_nxt    = SEND;
      end
      OPA: if (rx_vld) begin rf_we = 1'b1; rf_wa = '0; st_nxt = OPB; end
      OPB: if (rx_vld) begin rf_we = 1'b1; rf_wa = RF_ADDR'(1); st_nxt = ALU_FN; end
      ALU_FN: if (rx_vld) begin
        load_send = 1'b1;
        send_two  = 1'b1;
        st_nxt    = SEND;
      end
      // One frame per TX idle slot; leave only once the last frame is out.
      SEND: if (!tx_busy) begin
        if (send_cnt != 2'd0) tx_start = 1'b1;
        else st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
    // A corrupt frame aborts any half-received command; replies are never cut.
    if (rx_err && st != SEND) st_nxt = IDLE;
  end

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      st <= IDLE; addr_q <= '0; send_buf <= '0; send_cnt <= '0;
      for (int i = 0; i < 2**RF_ADDR; i++) rf[i] <= '0;
    end else begin
      st <= st_nxt;
      if (st == WR_ADDR && rx_vld) addr_q <= rx_dat[RF_ADDR-1:0];
      if (rf_we) rf[rf_wa] <= rx_dat;
      if (load_send) begin
        send_buf <= send_val;
        send_cnt <= send_two ? 2'd2 : 2'd1;
      end else if (tx_start) begin
        send_buf <= send_buf >> W;
        send_cnt <= send_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_system_top.sv
module tb_system_top;
  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;
  logic tx_out, par_err, frm_err;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    int         t;
  } frame_t;
  frame_t fq[$];

  system_top #(.BUS_WIDTH(8), .RF_ADDR(4), .CLKS_PER_BIT(CPB)) dut (
    .REF_CLK(clk), .RST(rst_n), .RX_IN(rx_in),
    .TX_OUT(tx_out), .parity_error(par_err), .framing_error(frm_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial decoder for TX_OUT: samples mid-bit, queues every frame seen.
  initial begin
    frame_t f;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (tx_out === 1'b0) begin
        f.t = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          repeat (CPB) @(negedge clk);
          bits[i] = tx_out;
        end
        f.d = bits[7:0];
        f.p = bits[8];
        f.s = bits[9];
        fq.push_back(f);
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic flip_par, input logic stop);
    logic [8:0] bits;
    bits = {(^d) ^ flip_par, d};
    @(negedge clk);
    rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      rx_in = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = stop;
    repeat (CPB) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_byte(d, 1'b0, 1'b1);
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (fq.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b expected 1", tx_out); else n_pass++;
    n_checks++;
    if (par_err !== 1'b0) $display("FAIL reset_parity_error: got %b expected 0", par_err); else n_pass++;
    n_checks++;
    if (frm_err !== 1'b0) $display("FAIL reset_framing_error: got %b expected 0", frm_err); else n_pass++;
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++;
    if (fq.size() != 0) $display("FAIL reset_idle_line: got %0d frames expected 0", fq.size()); else n_pass++;
  endtask

  task automatic test_write_read();
    bit ok;
    frame_t f;
    fq.delete();
    send_ok(8'hAA); send_ok(8'h04); send_ok(8'h12);
    send_ok(8'hBB); send_ok(8'h04);
    wait_frames(1, ok);
    n_checks++;
    if (!ok) $display("FAIL wr_rd_timeout: got %0d frames expected 1", fq.size());
    else begin
      n_pass++;
      f = fq.pop_front();
      n_checks++;
      if (f.d !== 8'h12) $display("FAIL wr_rd_data: got %h expected 12", f.d); else n_pass++;
      n_checks++;
      if (f.p !== 1'b0) $display("FAIL wr_rd_parity: got %b expected 0", f.p); else n_pass++;
      n_checks++;
      if (f.s !== 1'b1) $display("FAIL wr_rd_stop: got %b expected 1", f.s); else n_pass++;
    end
  endtask

  task automatic test_parity_error();
    bit ok;
    frame_t f;
    fq.delete();
    send_ok(8'hAA); send_ok(8'h05);
    send_byte(8'h12, 1'b1, 1'b1);
    n_checks++;
    if (par_err !== 1'b1) $display("FAIL par_flag_set: got %b expected 1", par_err); else n_pass++;
    n_checks++;
    if (frm_err !== 1'b0) $display("FAIL par_no_framing: got %b expected 0", frm_err); else n_pass++;
    send_ok(8'hBB); send_ok(8'h05);
    wait_frames(1, ok);
    f.d = 8'hXX;
    if (ok) f = fq.pop_front();
    n_checks++;
    if (f.d !== 8'h00) $display("FAIL par_rf_untouched: got %h expected 00", f.d); else n_pass++;
    send_ok(8'hAA); send_ok(8'h05); send_ok(8'h5F);
    send_ok(8'hBB); send_ok(8'h05);
    wait_frames(1, ok);
    f.d = 8'hXX;
    if (ok) f = fq.pop_front();
    n_checks++;
    if (f.d !== 8'h5F) $display("FAIL par_rewrite: got %h expected 5f", f.d); else n_pass++;
    n_checks++;
    if (par_err !== 1'b0) $display("FAIL par_flag_clear: got %b expected 0", par_err); else n_pass++;
  endtask

  typedef struct {
    logic        dd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  fn;
    logic [15:0] res;
  } alu_vec_t;

  task automatic test_alu_ops();
    alu_vec_t v[14];
    bit ok;
    frame_t lo, hi;
    v[0]  = '{1'b0, 8'h56, 8'h34, 8'h00, 16'h008A};
    v[1]  = '{1'b1, 8'h00, 8'h00, 8'h01, 16'h0022};
    v[2]  = '{1'b0, 8'hC2, 8'h08, 8'h02, 16'h0610};
    v[3]  = '{1'b1, 8'h00, 8'h00, 8'h03, 16'h0018};
    v[4]  = '{1'b0, 8'h6E, 8'h6E, 8'h09, 16'h00FF};
    v[5]  = '{1'b1, 8'h00, 8'h00, 8'h0A, 16'h0001};
    v[6]  = '{1'b1, 8'h00, 8'h00, 8'h0D, 16'h0037};
    v[7]  = '{1'b0, 8'hFF, 8'h01, 8'h00, 16'h0100};
    v[8]  = '{1'b0, 8'h05, 8'h07, 8'h01, 16'hFFFE};
    v[9]  = '{1'b1, 8'h00, 8'h00, 8'h0C, 16'h0001};
    v[10] = '{1'b1, 8'h00, 8'h00, 8'h0F, 16'h0000};
    v[11] = '{1'b0, 8'h09, 8'h00, 8'h03, 16'h0000};
    v[12] = '{1'b0, 8'h81, 8'h00, 8'h0E, 16'h0102};
    v[13] = '{1'b1, 8'h00, 8'h00, 8'h06, 16'h00FF};
    for (int k = 0; k < 14; k++) begin
      fq.delete();
      if (v[k].dd) send_ok(8'hDD);
      else begin send_ok(8'hCC); send_ok(v[k].a); send_ok(v[k].b); end
      send_ok(v[k].fn);
      wait_frames(2, ok);
      lo.d = 8'hXX; hi.d = 8'hXX; lo.p = 1'bx; hi.p = 1'bx;
      if (ok) begin lo = fq.pop_front(); hi = fq.pop_front(); end
      n_checks++;
      if ({hi.d, lo.d} !== v[k].res)
        $display("FAIL alu_vec%0d_result: got %h expected %h", k, {hi.d, lo.d}, v[k].res);
      else n_pass++;
      n_checks++;
      if ({hi.p, lo.p} !== {^v[k].res[15:8], ^v[k].res[7:0]})
        $display("FAIL alu_vec%0d_parity: got %b expected %b", k, {hi.p, lo.p},
                 {^v[k].res[15:8], ^v[k].res[7:0]});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    frame_t lo, hi;
    int gap;
    fq.delete();
    send_ok(8'hCC); send_ok(8'hFF); send_ok(8'hFF); send_ok(8'h02);
    wait_frames(2, ok);
    n_checks++;
    if (!ok) $display("FAIL b2b_timeout: got %0d frames expected 2", fq.size());
    else begin
      n_pass++;
      lo = fq.pop_front();
      hi = fq.pop_front();
      gap = hi.t - lo.t;
      n_checks++;
      if ({hi.d, lo.d} !== 16'hFE01) $display("FAIL b2b_result: got %h expected fe01", {hi.d, lo.d}); else n_pass++;
      n_checks++;
      if (gap < FRAME || gap > FRAME + 2)
        $display("FAIL b2b_gap: got %0d cycles expected %0d..%0d", gap, FRAME, FRAME + 2);
      else n_pass++;
    end
  endtask

  task automatic test_framing_error();
    bit ok;
    frame_t f;
    fq.delete();
    send_ok(8'hBB);
    send_byte(8'h33, 1'b0, 1'b0);
    n_checks++;
    if (frm_err !== 1'b1) $display("FAIL frm_flag_set: got %b expected 1", frm_err); else n_pass++;
    n_checks++;
    if (par_err !== 1'b0) $display("FAIL frm_no_parity: got %b expected 0", par_err); else n_pass++;
    // FSM must be back in IDLE, so this lone address byte is ignored.
    send_ok(8'h04);
    repeat (2 * FRAME) @(negedge clk);
    n_checks++;
    if (fq.size() != 0) $display("FAIL frm_fsm_idle: got %0d frames expected 0", fq.size()); else n_pass++;
    send_ok(8'hBB); send_ok(8'h04);
    wait_frames(1, ok);
    f.d = 8'hXX;
    if (ok) f = fq.pop_front();
    n_checks++;
    if (f.d !== 8'h12) $display("FAIL frm_recover: got %h expected 12", f.d); else n_pass++;
    n_checks++;
    if (frm_err !== 1'b0) $display("FAIL frm_flag_clear: got %b expected 0", frm_err); else n_pass++;
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    frame_t f;
    fq.delete();
    send_ok(8'hBB); send_ok(8'h04);
    for (int i = 0; i < 4 * FRAME && tx_out !== 1'b0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_out !== 1'b0) $display("FAIL rst_tx_started: got %b expected 0", tx_out); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1) $display("FAIL rst_tx_abort: got %b expected 1", tx_out); else n_pass++;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME + CPB) @(negedge clk);
    fq.delete();
    send_ok(8'hBB); send_ok(8'h04);
    wait_frames(1, ok);
    f.d = 8'hXX;
    if (ok) f = fq.pop_front();
    n_checks++;
    if (f.d !== 8'h00) $display("FAIL rst_rf4_clear: got %h expected 00", f.d); else n_pass++;
    send_ok(8'hBB); send_ok(8'h01);
    wait_frames(1, ok);
    f.d = 8'hXX;
    if (ok) f = fq.pop_front();
    n_checks++;
    if (f.d !== 8'h00) $display("FAIL rst_rf1_clear: got %h expected 00", f.d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_parity_error();
    test_alu_ops();
    test_back_to_back();
    test_framing_error();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
